// File: rtl/led_ctrl_pkg.sv
// Shared mode encoding for the multi-mode LED controller.
package led_ctrl_pkg;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_CHASE = 3'd3,
        MODE_PWM   = 3'd4
    } mode_e;

    localparam int NUM_MODES = 5;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_OFF:   return MODE_ON;
            MODE_ON:    return MODE_BLINK;
            MODE_BLINK: return MODE_CHASE;
            MODE_CHASE: return MODE_PWM;
            default:    return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/led_ctrl_btn_debounce.sv
// Button front end: 2-flop synchronizer, stability-count debouncer and
// registered rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1, sync2, btn_db, db_prev;
    logic [CW-1:0] cnt;

    // Everything resets to "pressed" so a button held through reset is
    // not seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            btn_db  <= 1'b1;
            db_prev <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            db_prev <= btn_db;
            press   <= btn_db & ~db_prev;
            if (sync2 == btn_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_ctrl_multi.sv
// Multi-mode LED controller: debounced button steps through
// OFF/ON/BLINK/CHASE/PWM; LED pattern registered one cycle behind mode.
module led_ctrl_multi
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS        = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_DIV       = 12000000,
    parameter int PWM_WIDTH       = 8,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn,
    input  logic [PWM_WIDTH-1:0] duty,
    output logic [NUM_LEDS-1:0]  led,
    output logic [2:0]           mode
);
    localparam int TW = $clog2(BLINK_DIV);

    mode_e                state_q, state_d;
    logic                 press, mode_chg, tick;
    logic [TW-1:0]        tick_cnt;
    logic                 phase;
    logic [NUM_LEDS-1:0]  chase, logical;
    logic [PWM_WIDTH-1:0] pwm_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= MODE_OFF;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MODE_OFF, MODE_ON, MODE_BLINK, MODE_CHASE, MODE_PWM:
                if (press) state_d = next_mode(state_q);
            default: state_d = MODE_OFF;
        endcase
    end

    assign mode_chg = (state_d != state_q);
    assign tick     = (tick_cnt == TW'(BLINK_DIV - 1));

    // A mode change wins over a coincident tick: the pattern restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            chase    <= NUM_LEDS'(1);
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_WIDTH'(1);
            if (mode_chg) begin
                tick_cnt <= '0;
                phase    <= 1'b0;
                chase    <= NUM_LEDS'(1);
            end else if (tick) begin
                tick_cnt <= '0;
                phase    <= ~phase;
                chase    <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    always_comb begin
        logical = '0;
        case (state_q)
            MODE_ON:    logical = '1;
            MODE_BLINK: logical = {NUM_LEDS{phase}};
            MODE_CHASE: logical = chase;
            MODE_PWM:   logical = {NUM_LEDS{pwm_cnt < duty}};
            default:    logical = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= {NUM_LEDS{ACTIVE_LOW}};
        else       led <= logical ^ {NUM_LEDS{ACTIVE_LOW}};
    end

    assign mode = state_q;

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Directed + randomized bench for led_ctrl_multi against a cycle-level
// behavioural model built from the mode/pattern rules.
module tb_led_ctrl_multi;
    localparam int DB = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic [3:0] duty;
    logic [2:0] led;
    logic [2:0] mode;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    logic [2:0] lhist [0:4095];
    logic [2:0] mhist [0:4095];

    // model state
    int m_s1, m_s2, m_db, m_run, m_rose, m_press, m_mode, m_since, m_pwm;
    logic [2:0] m_led;

    led_ctrl_multi #(
        .NUM_LEDS(3), .DEBOUNCE_CYCLES(DB), .BLINK_DIV(BD),
        .PWM_WIDTH(4), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .duty(duty), .led(led), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_db = 1; m_run = 0; m_rose = 0; m_press = 0;
        m_mode = 0; m_since = 0; m_pwm = 0; m_led = 3'b111;
    endtask

    function automatic logic [2:0] logical_leds();
        case (m_mode)
            1:       return 3'b111;
            2:       return ((m_since / BD) % 2 == 1) ? 3'b111 : 3'b000;
            3:       return 3'(1 << ((m_since / BD) % 3));
            4:       return (m_pwm < int'(duty)) ? 3'b111 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_step();
        logic [2:0] nl;
        if (reset) begin
            model_reset();
            return;
        end
        nl = logical_leds() ^ 3'b111;
        if (m_press != 0) begin
            m_mode = (m_mode + 1) % 5; m_since = 0;
        end else if (m_mode > 4) begin
            m_mode = 0; m_since = 0;
        end else begin
            m_since++;
        end
        m_pwm   = (m_pwm + 1) % 16;
        m_press = m_rose;
        m_rose  = 0;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_rose = m_s2; m_db = m_s2; m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2  = m_s1;
        m_s1  = int'(btn);
        m_led = nl;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        lhist[cyc_n % 4096] = led;
        mhist[cyc_n % 4096] = mode;
        chk("mode", 32'(mode), 32'(m_mode));
        chk("led", 32'(led), 32'(m_led));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press_btn();
        btn = 1'b1; run(10);
        btn = 1'b0; run(10);
    endtask

    initial begin
        int st, cnt;
        reset = 1'b1; btn = 1'b0; duty = 4'd0;
        model_reset();
        run(3);
        chk("reset_led", 32'(led), 32'(3'b111));
        chk("reset_mode", 32'(mode), 32'd0);
        reset = 1'b0;
        run(8);

        // clean press: mode 1 exactly 8 cycles after btn rise
        st = cyc_n;
        press_btn();
        chk("lat_mode7", 32'(mhist[st + 7]), 32'd0);
        chk("lat_mode8", 32'(mhist[st + 8]), 32'd1);
        chk("lat_led8", 32'(lhist[st + 8]), 32'(3'b111));
        chk("lat_led9", 32'(lhist[st + 9]), 32'(3'b000));

        // short glitches must be rejected
        for (int g = 0; g < 5; g++) begin
            btn = 1'b1; run(3);
            btn = 1'b0; run(1);
        end
        run(10);
        chk("glitch_mode", 32'(mode), 32'd1);

        // into BLINK, then asynchronous reset mid-mode
        press_btn();
        chk("blink_mode", 32'(mode), 32'd2);
        run(13);
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_led", 32'(led), 32'(3'b111));
        chk("async_mode", 32'(mode), 32'd0);
        btn = 1'b1;
        run(2);
        reset = 1'b0;
        run(20);
        chk("held_no_press", 32'(mode), 32'd0);
        btn = 1'b0; run(10);
        chk("release_no_press", 32'(mode), 32'd0);
        press_btn();
        chk("repress", 32'(mode), 32'd1);

        // five presses from OFF, with CHASE and PWM checks on the way
        reset = 1'b1; run(2); reset = 1'b0; run(8);
        for (int k = 1; k <= 5; k++) begin
            st = cyc_n;
            press_btn();
            chk("seq_mode", 32'(mode), 32'(k % 5));
            if (k == 3) begin
                run(20);
                chk("chase_1", 32'(lhist[st + 9]), 32'(3'b110));
                chk("chase_8", 32'(lhist[st + 16]), 32'(3'b110));
                chk("chase_9", 32'(lhist[st + 17]), 32'(3'b101));
                chk("chase_17", 32'(lhist[st + 25]), 32'(3'b011));
                chk("chase_25", 32'(lhist[st + 33]), 32'(3'b110));
            end
            if (k == 4) begin
                duty = 4'd4; run(2); st = cyc_n; run(16); cnt = 0;
                for (int i = 1; i <= 16; i++) if (lhist[st + i] == 3'b000) cnt++;
                chk("pwm4_lit", cnt, 4);
                duty = 4'd0; run(2); st = cyc_n; run(16); cnt = 0;
                for (int i = 1; i <= 16; i++) if (lhist[st + i] == 3'b111) cnt++;
                chk("pwm0_dark", cnt, 16);
                duty = 4'd15; run(2); st = cyc_n; run(16); cnt = 0;
                for (int i = 1; i <= 16; i++) if (lhist[st + i] == 3'b111) cnt++;
                chk("pwm15_dark", cnt, 1);
            end
        end

        // illegal code recovers to OFF on the next cycle
        force dut.state_q = led_ctrl_pkg::mode_e'(3'd6);
        m_mode = 6;
        #1;
        chk("forced_code", 32'(mode), 32'd6);
        #3;
        release dut.state_q;
        cyc();
        chk("illegal_recover", 32'(mode), 32'd0);

        // randomized button bursts and duty values against the model
        for (int r = 0; r < 10; r++) begin
            duty = 4'($urandom_range(0, 15));
            for (int b = 0; b < 8; b++) begin
                btn = ~btn;
                run($urandom_range(1, 9));
            end
            btn = 1'b0;
            run($urandom_range(20, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_ctrl_multi.md
LED_CTRL_MULTI -- requirements
Module: led_ctrl_multi

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_LEDS, 3, number of LED outputs (>=2)
- DEBOUNCE_CYCLES, 250000, stable-cycle count required to accept a button level change (>=2)
- BLINK_DIV, 12000000, clock cycles per blink/chase tick (>=2)
- PWM_WIDTH, 8, PWM counter and duty width
- ACTIVE_LOW, 1, 1 = LED lit when output is 0
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock
- reset, in, 1, asynchronous, active-high reset
- btn, in, 1, raw asynchronous push-button, 1 = pressed
- duty, in, PWM_WIDTH, PWM on-count, sampled every cycle
- led, out, NUM_LEDS, LED drive, polarity per ACTIVE_LOW
- mode, out, 3, current mode code

Function
REQ-003 btn SHALL pass through a 2-flop synchronizer before any use.
REQ-004 The debouncer SHALL update its debounced level btn_db only after the synchronized input differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any cycle of agreement SHALL clear the stability counter.
REQ-005 A press SHALL be a one-cycle pulse on each 0->1 transition of btn_db; a 1->0 transition SHALL generate nothing.
REQ-006 The mode FSM SHALL cycle OFF(0) -> ON(1) -> BLINK(2) -> CHASE(3) -> PWM(4) -> OFF, advancing one state in the cycle after a press pulse.
REQ-007 Codes 5-7 SHALL be unreachable; if entered, the FSM SHALL go to OFF on the next cycle.
REQ-008 The tick counter SHALL count 0..BLINK_DIV-1 and assert tick in the cycle it equals BLINK_DIV-1, then wrap to 0.
REQ-009 Logical LED state SHALL be:
- OFF: all 0
- ON: all 1
- BLINK: all equal to a phase bit that toggles on each tick
- CHASE: one-hot, bit 0 first, rotating toward the MSB on each tick, MSB wrapping to bit 0
- PWM: all equal (pwm_cnt < duty)
REQ-010 pwm_cnt SHALL be a free-running PWM_WIDTH-bit counter that wraps modulo 2^PWM_WIDTH; duty=0 SHALL give always off, and duty=2^PWM_WIDTH-1 SHALL give off for 1 cycle per period.
REQ-011 On every mode change, the tick counter, blink phase (to 0), and chase index (to bit 0) SHALL restart in the same cycle the new mode is registered.
REQ-012 led SHALL be registered, equal to the logical state XOR ACTIVE_LOW, lagging mode by one cycle.
REQ-013 mode SHALL be registered, so a btn edge reaches mode after 2 sync + DEBOUNCE_CYCLES + 1 press + 1 FSM cycles.
REQ-014 A press arriving in the same cycle as a tick SHALL take priority: the mode advances and the counters restart per REQ-011.

Reset
REQ-015 reset SHALL asynchronously set mode=OFF, all counters=0, phase=0, chase index=bit 0, and led=all ACTIVE_LOW (LEDs dark).
REQ-016 reset SHALL set the synchronizer flops and btn_db to 1, so a button held across reset release produces no press until it is released and pressed again.
REQ-017 reset asserted mid-debounce or mid-mode SHALL discard all in-progress state, with no press pulse on release.

Structure
REQ-018 The mode enumeration (OFF..PWM, 3-bit) and the mode count SHALL live in the shared package led_ctrl_pkg.
REQ-019 Synchronizer, debouncer, and press detector SHALL be one sub-module, btn_debounce (params DEBOUNCE_CYCLES; ports clk, reset, btn, press).

Verification (NUM_LEDS=3, DEBOUNCE_CYCLES=4, BLINK_DIV=8, PWM_WIDTH=4, ACTIVE_LOW=1)
REQ-020 Reset, btn=0 -> led=3'b111 and mode=0; a clean press held 10 cycles -> mode=1 exactly 8 cycles after the btn rise, and led=3'b000 one cycle later.
REQ-021 btn glitch high for 3 cycles, repeated 5 times with 1-cycle gaps -> mode stays 0.
REQ-022 mode=3 -> led walks 110, 101, 011, 110, changing every 8 cycles.
REQ-023 mode=4, duty=4 -> led low for 4 of every 16 cycles; duty=0 -> led constantly 3'b111; duty=15 -> led high for 1 cycle per 16.
REQ-024 btn held high while reset pulses -> no mode change until btn goes low then high; reset mid-BLINK -> led=3'b111 immediately (asynchronous).
REQ-025 Five presses from OFF -> mode visits 1,2,3,4,0 in order; forcing mode to 6 -> mode=0 on the next cycle.
